// File: rtl/stopwatch_control.sv
// Stopwatch run/pause/clear controller feeding cascaded BCD digit counters.
// Latency: raw button edge to state/clear update is DEBOUNCE_CYCLES+3 clocks; no backpressure (outputs are pulses/levels).

module stopwatch_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DB_BITS         = 20
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press
);

    localparam logic [DB_BITS-1:0] DB_LAST = DB_BITS'(DEBOUNCE_CYCLES - 1);

    logic [1:0]         r_sync;
    logic [DB_BITS-1:0] r_cnt;
    logic               r_level;
    logic               r_level_d;

    // Counter restarts whenever the synchronized input agrees with the accepted level,
    // so only an uninterrupted run of DEBOUNCE_CYCLES disagreeing samples flips it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync    <= 2'b00;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_btn};
            r_level_d <= r_level;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == DB_LAST) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + DB_BITS'(1);
            end
        end
    end

    assign o_press = r_level & ~r_level_d;

endmodule

module stopwatch_control #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_DIV        = 1_000_000,
    parameter int DB_BITS         = 20,
    parameter int TICK_BITS       = 20
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_start_stop,
    input  logic       i_btn_clear,
    input  logic       i_sw_direction,
    input  logic       i_zero_reached,
    output logic       o_count_enable,
    output logic       o_up_down,
    output logic       o_clear,
    output logic       o_running,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        DONE    = 2'b11
    } state_t;

    localparam logic [TICK_BITS-1:0] TICK_LAST = TICK_BITS'(TICK_DIV - 1);

    state_t               r_state;
    logic [TICK_BITS-1:0] r_prescaler;
    logic                 r_count_enable;
    logic                 r_up_down;
    logic                 r_clear;
    logic                 r_running;

    logic w_start_evt;
    logic w_clear_evt;
    logic w_tick;
    logic w_hit_zero;

    stopwatch_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_BITS         (DB_BITS)
    ) u_db_start (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_btn_start_stop),
        .o_press (w_start_evt)
    );

    stopwatch_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_BITS         (DB_BITS)
    ) u_db_clear (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_btn_clear),
        .o_press (w_clear_evt)
    );

    assign w_tick     = (r_state == RUNNING) && (r_prescaler == TICK_LAST);
    // Counting down onto all-zero digits: stop here rather than let the tick wrap them.
    assign w_hit_zero = w_tick && !r_up_down && i_zero_reached;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= IDLE;
            r_prescaler    <= '0;
            r_count_enable <= 1'b0;
            r_up_down      <= 1'b1;
            r_clear        <= 1'b0;
            r_running      <= 1'b0;
        end else begin
            r_count_enable <= 1'b0;
            r_clear        <= 1'b0;
            if (w_clear_evt) begin
                r_state     <= IDLE;
                r_clear     <= 1'b1;
                r_prescaler <= '0;
                r_running   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_prescaler <= '0;
                        r_up_down   <= i_sw_direction;
                        if (w_start_evt) begin
                            r_state   <= RUNNING;
                            r_running <= 1'b1;
                        end
                    end
                    RUNNING: begin
                        if (w_hit_zero) begin
                            r_state     <= DONE;
                            r_running   <= 1'b0;
                            r_prescaler <= '0;
                        end else begin
                            r_count_enable <= w_tick;
                            r_prescaler    <= w_tick ? '0 : r_prescaler + TICK_BITS'(1);
                            if (w_start_evt) begin
                                r_state   <= PAUSED;
                                r_running <= 1'b0;
                            end
                        end
                    end
                    PAUSED: begin
                        if (w_start_evt) begin
                            r_state   <= RUNNING;
                            r_running <= 1'b1;
                        end
                    end
                    DONE: begin
                        r_prescaler <= '0;
                    end
                endcase
            end
        end
    end

    assign o_count_enable = r_count_enable;
    assign o_up_down      = r_up_down;
    assign o_clear        = r_clear;
    assign o_running      = r_running;
    assign o_state        = r_state;

endmodule

// File: tb/tb_stopwatch_control.sv
// Bench for stopwatch_control with DEBOUNCE_CYCLES=4, TICK_DIV=5: stimulus table plus
// expected-output scoreboard keyed on clock cycle, and pulse-count windows for corner cases.

module tb_stopwatch_control;

    logic       clk = 1'b0;
    logic       rst;
    logic       bss;
    logic       bclr;
    logic       dir;
    logic       zero;
    logic       ce;
    logic       ud;
    logic       clr;
    logic       run;
    logic [1:0] st;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;
    int n_ce_run;
    int n_ce_pause;
    int n_clr_w;
    int n_ce_rst;
    int n_clr_rst;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic       ce;
        logic       clr;
        logic       run;
        logic       ud;
        string      name;
    } exp_t;

    typedef struct {
        int         at;
        logic       rst;
        logic       bss;
        logic       bclr;
        logic       dir;
        logic       zero;
        int         chk;
        logic [1:0] st;
        logic       ce;
        logic       clr;
        logic       run;
        logic       ud;
        string      name;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[$];
    exp_t mon_x;

    stopwatch_control #(
        .DEBOUNCE_CYCLES (4),
        .TICK_DIV        (5),
        .DB_BITS         (4),
        .TICK_BITS       (4)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_btn_start_stop (bss),
        .i_btn_clear      (bclr),
        .i_sw_direction   (dir),
        .i_zero_reached   (zero),
        .o_count_enable   (ce),
        .o_up_down        (ud),
        .o_clear          (clr),
        .o_running        (run),
        .o_state          (st)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_exp(input int c, input logic [1:0] s, input logic e, input logic k,
                            input logic r, input logic u, input string nm);
        exp_t x;
        int   i;
        x.cyc = c; x.st = s; x.ce = e; x.clr = k; x.run = r; x.ud = u; x.name = nm;
        i = 0;
        while (i < exp_q.size() && exp_q[i].cyc <= c) i++;
        exp_q.insert(i, x);
    endtask

    task automatic row(input int at, input logic r, input logic b, input logic k, input logic d,
                       input logic z, input int chk, input logic [1:0] s, input logic e,
                       input logic cl, input logic rn, input logic u, input string nm);
        vec_t v;
        v.at = at; v.rst = r; v.bss = b; v.bclr = k; v.dir = d; v.zero = z;
        v.chk = chk; v.st = s; v.ce = e; v.clr = cl; v.run = rn; v.ud = u; v.name = nm;
        tbl.push_back(v);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_val(input string nm, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endtask

    task automatic count_pulses(input int from, input int to, input bit sel_clr, output int n);
        n = 0;
        while (cyc < to) begin
            @(negedge clk);
            if (cyc >= from && cyc <= to) n += sel_clr ? int'(clr) : int'(ce);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_x = exp_q.pop_front();
            n_checks++;
            if (mon_x.cyc != cyc) begin
                n_errors++;
                $display("FAIL %s: check for cycle %0d reached late at cycle %0d",
                         mon_x.name, mon_x.cyc, cyc);
            end else if ({st, ce, clr, run, ud} !==
                         {mon_x.st, mon_x.ce, mon_x.clr, mon_x.run, mon_x.ud}) begin
                n_errors++;
                $display("FAIL %s @cyc %0d: got st=%b ce=%b clr=%b run=%b ud=%b, expected st=%b ce=%b clr=%b run=%b ud=%b",
                         mon_x.name, cyc, st, ce, clr, run, ud,
                         mon_x.st, mon_x.ce, mon_x.clr, mon_x.run, mon_x.ud);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; bss = 1'b0; bclr = 1'b0; dir = 1'b1; zero = 1'b0;

        //   at   rst bss clr dir zro  chk  st    ce clr run ud  name
        row(  1, 1, 0, 0, 1, 0,   2, 2'b00, 0, 0, 0, 1, "reset");
        row(  2, 0, 0, 0, 1, 0,   3, 2'b00, 0, 0, 0, 1, "idle_after_rst");
        row(  5, 0, 1, 0, 1, 0,   6, 2'b00, 0, 0, 0, 1, "bounce_1");
        row(  7, 0, 0, 0, 1, 0,   8, 2'b00, 0, 0, 0, 1, "bounce_2");
        row(  9, 0, 1, 0, 1, 0,  10, 2'b00, 0, 0, 0, 1, "bounce_3");
        row( 11, 0, 0, 0, 1, 0,  12, 2'b00, 0, 0, 0, 1, "bounce_4");
        row( 13, 0, 1, 0, 1, 0,  19, 2'b00, 0, 0, 0, 1, "start_not_early");
        row( 14, 0, 1, 0, 1, 0,  20, 2'b01, 0, 0, 1, 1, "start_latency");
        row( 21, 0, 0, 0, 1, 0,   0, 2'b00, 0, 0, 0, 0, "");
        row( 40, 0, 1, 0, 1, 0,  46, 2'b01, 0, 0, 1, 1, "pre_pause");
        row( 41, 0, 1, 0, 1, 0,  47, 2'b10, 0, 0, 0, 1, "paused");
        row( 48, 0, 0, 0, 1, 0,  60, 2'b10, 0, 0, 0, 1, "pause_hold");
        row( 90, 0, 1, 0, 1, 0,  96, 2'b10, 0, 0, 0, 1, "pre_resume");
        row( 91, 0, 1, 0, 1, 0,  97, 2'b01, 0, 0, 1, 1, "resumed");
        row( 92, 0, 1, 0, 1, 0,  99, 2'b01, 0, 0, 1, 1, "resume_partial");
        row( 93, 0, 1, 0, 1, 0, 100, 2'b01, 1, 0, 1, 1, "resume_tick_3cyc");
        row( 98, 0, 0, 0, 1, 0, 101, 2'b01, 0, 0, 1, 1, "resume_tick_1wide");
        row(105, 0, 0, 0, 0, 0, 106, 2'b01, 0, 0, 1, 1, "ud_frozen_running");
        row(110, 0, 1, 1, 0, 0, 116, 2'b01, 0, 0, 1, 1, "pre_start_clear");
        row(111, 0, 1, 1, 0, 0, 117, 2'b00, 0, 1, 0, 1, "clear_beats_start");
        row(112, 0, 1, 1, 0, 0, 118, 2'b00, 0, 0, 0, 0, "clear_1wide_ud_resample");
        row(118, 0, 0, 0, 0, 0, 120, 2'b00, 0, 0, 0, 0, "idle_no_tick");
        row(126, 0, 1, 0, 0, 1, 133, 2'b01, 0, 0, 1, 0, "down_start");
        row(127, 0, 1, 0, 0, 1, 137, 2'b01, 0, 0, 1, 0, "down_pre_done");
        row(128, 0, 1, 0, 0, 1, 138, 2'b11, 0, 0, 0, 0, "down_done_no_ce");
        row(134, 0, 0, 0, 0, 1, 139, 2'b11, 0, 0, 0, 0, "done_hold");
        row(142, 0, 1, 0, 0, 1, 150, 2'b11, 0, 0, 0, 0, "done_ignores_start");
        row(150, 0, 0, 0, 0, 1,   0, 2'b00, 0, 0, 0, 0, "");
        row(152, 0, 0, 1, 0, 1, 159, 2'b00, 0, 1, 0, 0, "clear_from_done");
        row(153, 0, 0, 1, 0, 1, 160, 2'b00, 0, 0, 0, 0, "clear_done_1wide");
        row(160, 0, 0, 0, 0, 1,   0, 2'b00, 0, 0, 0, 0, "");
        row(168, 0, 0, 1, 0, 1, 175, 2'b00, 0, 1, 0, 0, "clear_in_idle");
        row(169, 0, 0, 1, 0, 1, 176, 2'b00, 0, 0, 0, 0, "clear_idle_1wide");
        row(176, 0, 0, 0, 1, 0,   0, 2'b00, 0, 0, 0, 0, "");
        row(184, 0, 1, 0, 1, 0, 191, 2'b01, 0, 0, 1, 1, "restart");
        row(192, 0, 0, 0, 1, 0, 194, 2'b01, 0, 0, 1, 1, "pre_rst");
        row(194, 1, 0, 0, 1, 0, 195, 2'b00, 0, 0, 0, 1, "mid_run_rst");
        row(195, 0, 0, 0, 1, 0, 196, 2'b00, 0, 0, 0, 1, "post_rst");
        row(196, 0, 0, 0, 1, 0, 200, 2'b00, 0, 0, 0, 1, "post_rst_quiet");

        // Running from cycle 20 with up_down=1: one tick every TICK_DIV cycles.
        for (int c = 21; c <= 43; c++)
            push_exp(c, 2'b01, ((c - 20) % 5) == 0, 1'b0, 1'b1, 1'b1, "run_tick");

        fork
            begin
                foreach (tbl[i]) begin
                    wait_cyc(tbl[i].at);
                    rst = tbl[i].rst; bss = tbl[i].bss; bclr = tbl[i].bclr;
                    dir = tbl[i].dir; zero = tbl[i].zero;
                    if (tbl[i].chk > 0)
                        push_exp(tbl[i].chk, tbl[i].st, tbl[i].ce, tbl[i].clr,
                                 tbl[i].run, tbl[i].ud, tbl[i].name);
                end
            end
            begin
                count_pulses(21, 43, 1'b0, n_ce_run);
                check_val("ce_count_23_cycles", n_ce_run, 4);
            end
            begin
                count_pulses(48, 96, 1'b0, n_ce_pause);
                check_val("no_ce_while_paused", n_ce_pause, 0);
            end
            begin
                count_pulses(110, 125, 1'b1, n_clr_w);
                check_val("clear_pulse_width", n_clr_w, 1);
            end
            begin
                count_pulses(195, 205, 1'b0, n_ce_rst);
                check_val("post_rst_no_ce", n_ce_rst, 0);
            end
            begin
                count_pulses(195, 205, 1'b1, n_clr_rst);
                check_val("post_rst_no_clear", n_clr_rst, 0);
            end
        join

        @(negedge clk);
        check_val("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
